// File: rtl/seq_add_sub_pkg.sv
// Shared ALU definitions: FSM state encoding and CTRL opcodes for the
// multi-cycle adder/subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_add_sub_seg.sv
// Ripple-carry segment adder built from full_adder cells; also exposes the
// carry into its top bit so the caller can form signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);
  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];
endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle add/sub: one SEG-bit segment rippled per clock, valid/ready on
// both sides, carry/borrow, signed-overflow and zero flags.
module seq_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CTRL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH:0]   S,
  output logic             OVF,
  output logic             ZERO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_n, seg_mask;
  logic             ctrl_r, carry_r;
  logic [IDXW-1:0]  idx;
  logic             accept, last;
  logic [SEG-1:0]   a_seg, b_seg, sum_seg;
  logic             cout_seg, cmsb_seg;
  int unsigned      shamt;

  // Single segment adder shared across cycles; idx picks the slice.
  always_comb begin
    shamt    = 32'(idx) * 32'(SEG);
    a_seg    = SEG'(a_r >> shamt);
    b_seg    = SEG'(b_r >> shamt);
    seg_mask = WIDTH'({SEG{1'b1}}) << shamt;
    acc_n    = (acc & ~seg_mask) | (WIDTH'(sum_seg) << shamt);
    last     = (idx == IDXW'(NSEG - 1));
  end

  seg_adder #(
    .SEG (SEG)
  ) u_seg (
    .a        (a_seg),
    .b        (b_seg),
    .cin      (carry_r),
    .sum      (sum_seg),
    .cout     (cout_seg),
    .c_msb_in (cmsb_seg)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    IN_READY = 1'b0;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_n = ST_DONE;
      end
      ST_DONE: begin
        IN_READY = OUT_READY;
        if (OUT_READY) begin
          if (IN_VALID) begin
            accept  = 1'b1;
            state_n = ST_RUN;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (RST) begin
      IN_READY = 1'b0;
      accept   = 1'b0;
    end
  end

  assign OUT_VALID = (state == ST_DONE);

  // Result registers only load on the final segment, so a partial sum is
  // never visible on S even though acc changes every RUN cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      ctrl_r  <= 1'b0;
      carry_r <= 1'b0;
      idx     <= '0;
      S       <= '0;
      OVF     <= 1'b0;
      ZERO    <= 1'b0;
    end else begin
      if (accept) begin
        a_r     <= A;
        b_r     <= B ^ {WIDTH{CTRL == OP_SUB}};
        ctrl_r  <= CTRL;
        carry_r <= CTRL;
        idx     <= '0;
      end else if (state == ST_RUN) begin
        acc     <= acc_n;
        carry_r <= cout_seg;
        idx     <= idx + 1'b1;
        if (last) begin
          S    <= {cout_seg ^ ctrl_r, acc_n};
          OVF  <= cmsb_seg ^ cout_seg;
          ZERO <= (acc_n == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: directed and random operations on a
// WIDTH=16/SEG=4 instance, plus latency checks on SEG=16 and SEG=1 instances.
module tb_seq_add_sub;
  localparam int W    = 16;
  localparam int SEGM = 4;
  localparam int NSEG = W / SEGM;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST, CTRL, IN_VALID, OUT_READY, IN_READY, OVF, ZERO, OUT_VALID;
  logic [W-1:0] A, B;
  logic [W:0]   S;
  logic         iv16, rdy16, ovf16, zero16, ov16;
  logic [W:0]   s16;
  logic         iv1, rdy1, ovf1, zero1, ov1;
  logic [W:0]   s1;

  seq_add_sub #(.WIDTH(W), .SEG(SEGM)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .CTRL(CTRL), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .S(S), .OVF(OVF), .ZERO(ZERO), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY));

  seq_add_sub #(.WIDTH(W), .SEG(16)) dut16 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .CTRL(CTRL), .IN_VALID(iv16),
    .IN_READY(rdy16), .S(s16), .OVF(ovf16), .ZERO(zero16), .OUT_VALID(ov16),
    .OUT_READY(1'b1));

  seq_add_sub #(.WIDTH(W), .SEG(1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .CTRL(CTRL), .IN_VALID(iv1),
    .IN_READY(rdy1), .S(s1), .OVF(ovf1), .ZERO(zero1), .OUT_VALID(ov1),
    .OUT_READY(1'b1));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit bp_rand  = 1'b0;
  bit head_seen = 1'b0;

  typedef struct packed {
    logic [W:0]  s;
    logic        ovf;
    logic        zero;
    logic [31:0] lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always @(posedge CLK) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, int lat);
    exp_t   r;
    longint ua, ub, sa, sb, u, sr;
    logic   cb;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (c == 1'b0) begin
      u  = ua + ub;
      sr = sa + sb;
      cb = (u >= 65536);
    end else begin
      u  = ua - ub;
      sr = sa - sb;
      cb = (ua < ub);
    end
    r.s    = {cb, W'(u)};
    r.ovf  = (sr > 32767) || (sr < -32768);
    r.zero = (W'(u) == '0);
    r.lat  = 32'(lat);
    return r;
  endfunction

  always @(posedge CLK) begin
    #1;
    if (bp_rand) OUT_READY = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every cycle the DUT presents a result it must match the head
  // of the queue; the entry retires only when the consumer takes it.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got S=0x%0h expected no result", S);
      end else begin
        e = exp_q[0];
        chk("S", 32'(S), 32'(e.s));
        chk("OVF", 32'(OVF), 32'(e.ovf));
        chk("ZERO", 32'(ZERO), 32'(e.zero));
        if (!head_seen) begin
          chk("latency_cycle", 32'(cyc), e.lat);
          head_seen = 1'b1;
        end
        if (OUT_READY) begin
          void'(exp_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic c);
    int waited = 0;
    A = a; B = b; CTRL = c; IN_VALID = 1'b1;
    forever begin
      @(negedge CLK);
      if (IN_READY) begin
        exp_q.push_back(model(a, b, c, cyc + 1 + NSEG));
        break;
      end
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout: got IN_READY=0 for 200 cycles expected 1");
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic lat_test(int sel, int exp_n);
    int   n = 0;
    logic ov;
    A = 16'h1234; B = 16'h1234; CTRL = 1'b1;
    if (sel == 0) iv16 = 1'b1; else iv1 = 1'b1;
    @(negedge CLK);
    chk("seg_in_ready", 32'((sel == 0) ? rdy16 : rdy1), 32'd1);
    @(posedge CLK); #1;
    iv16 = 1'b0; iv1 = 1'b0;
    do begin
      @(posedge CLK); #1;
      n++;
      ov = (sel == 0) ? ov16 : ov1;
    end while (!ov && n < 40);
    chk("seg_latency", 32'(n), 32'(exp_n));
    chk("seg_S", 32'((sel == 0) ? s16 : s1), 32'd0);
    chk("seg_ZERO", 32'((sel == 0) ? zero16 : zero1), 32'd1);
    chk("seg_OVF", 32'((sel == 0) ? ovf16 : ovf1), 32'd0);
  endtask

  logic [W-1:0] specials [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; iv16 = 1'b0; iv1 = 1'b0;
    A = '0; B = '0; CTRL = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_OVF", 32'(OVF), 32'd0);
    chk("rst_ZERO", 32'(ZERO), 32'd0);
    chk("rst_OUT_VALID", 32'(OUT_VALID), 32'd0);
    chk("rst_IN_READY", 32'(IN_READY), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Directed arithmetic, issued back to back with the consumer always ready.
    issue(16'h00FF, 16'h0001, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1);
    issue(16'h1234, 16'h1234, 1'b1);
    drain();

    // Backpressure: result held in DONE while a new operand waits.
    OUT_READY = 1'b0;
    issue(16'hABCD, 16'h1111, 1'b0);
    for (int i = 0; i < 20 && !OUT_VALID; i++) @(negedge CLK);
    chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
    @(posedge CLK); #1;
    A = 16'h4000; B = 16'h4000; CTRL = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(IN_READY), 32'd0);
      chk("bp_hold_valid", 32'(OUT_VALID), 32'd1);
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    issue(16'h4000, 16'h4000, 1'b0);
    drain();

    // Reset while RUN is at segment index 2.
    issue(16'h1111, 16'h2222, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    void'(exp_q.pop_back());
    @(posedge CLK); #1;
    chk("midrst_OUT_VALID", 32'(OUT_VALID), 32'd0);
    chk("midrst_S", 32'(S), 32'd0);
    chk("midrst_IN_READY", 32'(IN_READY), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_idle_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    issue(16'h0001, 16'h0001, 1'b0);
    drain();

    // Random operations with random consumer stalls and idle gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(pick(), pick(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
    end
    drain();
    bp_rand = 1'b0;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;

    lat_test(0, 1);
    lat_test(1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule
